// File: rtl/cpu_clock_controller.sv
// Turns the divider's slow square wave into single-cycle core enables on the board clock,
// with run/halt/single-step control and an issued-cycle counter.

module cpu_clock_controller_cond #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          sa, sb;
  logic [DW-1:0] cnt;

  // Any sample agreeing with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa  <= 1'b0;
      sb  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      sa <= raw;
      sb <= sa;
      if (sb == db) begin
        cnt <= '0;
      end else if (cnt == DW'(DEB_CYCLES - 1)) begin
        db  <= sb;
        cnt <= '0;
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
  end
endmodule

module cpu_clock_controller #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic             inp_clk,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);
  typedef enum logic [1:0] {HALT, RUN, STEP_ARMED} state_t;

  state_t     state;
  logic       s1, s2, tick;
  logic [1:0] raw, db;
  logic       run_db, step_db, step_q, step_press;

  assign raw = {step_btn, run_sw};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_cond
      cpu_clock_controller_cond #(.DEB_CYCLES(DEB_CYCLES)) u_cond (
        .clk   (inp_clk),
        .rst_n (rst_n),
        .raw   (raw[i]),
        .db    (db[i])
      );
    end
  endgenerate

  assign run_db     = db[0];
  assign step_db    = db[1];
  assign step_press = step_db & ~step_q;
  assign tick       = s1 & ~s2;

  always_ff @(posedge inp_clk) begin
    if (!rst_n) begin
      state       <= HALT;
      running     <= 1'b0;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      s1          <= slow_clk;
      s2          <= s1;
      step_q      <= step_db;
      cycle_count <= cycle_count + CNT_W'(cpu_en);
      // Pulse is decided from the current state, so a tick coinciding with
      // leaving HALT yields nothing; STEP_ARMED deliberately ignores halt_req.
      cpu_en <= tick & (((state == RUN) & run_db & ~halt_req) | (state == STEP_ARMED));
      case (state)
        HALT: begin
          if (run_db && !halt_req) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (step_press) begin
            state <= STEP_ARMED;
          end
        end
        RUN: begin
          if (!run_db || halt_req) begin
            state   <= HALT;
            running <= 1'b0;
          end
        end
        STEP_ARMED: begin
          if (tick) state <= HALT;
        end
        default: begin
          state   <= HALT;
          running <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed bench: slow_clk period 20 fast cycles, DEB_CYCLES=4, CNT_W=8.

module tb_cpu_clock_controller;
  logic       clk, rst_n, slow_clk, run_sw, step_btn, halt_req;
  logic       cpu_en, running;
  logic [7:0] cycle_count;

  int total = 0, bad = 0;
  int ph, pulses, n;
  logic frz;

  cpu_clock_controller #(.DEB_CYCLES(4), .CNT_W(8)) dut (
    .inp_clk     (clk),
    .rst_n       (rst_n),
    .slow_clk    (slow_clk),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .cpu_en      (cpu_en),
    .running     (running),
    .cycle_count (cycle_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One fast cycle; slow_clk is 1 for ph 0..9. A pulse is observed when ph==2.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (cpu_en) pulses++;
    if (!frz) begin
      ph = (ph + 1) % 20;
      slow_clk = (ph < 10);
    end
  endtask

  task automatic until_ph(input int p);
    do cyc(); while (ph != p);
  endtask

  task automatic lat_run(output int cnt);
    cnt = 0;
    while (!running && cnt < 50) begin
      cyc();
      cnt++;
    end
  endtask

  // Bounce 1,0,1 then hold high; caller releases.
  task automatic press(input int hold);
    step_btn = 1'b1; cyc();
    step_btn = 1'b0; cyc();
    step_btn = 1'b1; cyc();
    repeat (hold) cyc();
  endtask

  initial begin
    rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    ph = 10; slow_clk = 1'b0; frz = 1'b0; pulses = 0;
    repeat (3) cyc();
    chk("rst_en", int'(cpu_en), 0);
    chk("rst_run", int'(running), 0);
    chk("rst_cnt", int'(cycle_count), 0);
    rst_n = 1'b1;

    pulses = 0;
    repeat (200) cyc();
    chk("idle_pulses", pulses, 0);
    chk("idle_run", int'(running), 0);
    chk("idle_cnt", int'(cycle_count), 0);

    until_ph(0);
    run_sw = 1'b1;
    lat_run(n);
    chk("run_lat", n, 7);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      chk("run_en", int'(cpu_en), int'(ph == 2));
    end
    chk("run_pulses", pulses, 5);
    chk("run_cnt", int'(cycle_count), 5);

    until_ph(1);
    halt_req = 1'b1;
    cyc();
    chk("halt_en", int'(cpu_en), 0);
    chk("halt_run", int'(running), 0);
    halt_req = 1'b0;
    cyc();
    chk("resume_run", int'(running), 1);
    until_ph(2);
    chk("resume_en", int'(cpu_en), 1);
    cyc();
    chk("resume_cnt", int'(cycle_count), 6);

    run_sw = 1'b0;
    repeat (10) cyc();
    chk("stop_run", int'(running), 0);
    pulses = 0;
    until_ph(3);
    chk("halt_idle", pulses, 0);

    press(10);
    step_btn = 1'b0;
    frz = 1'b1;
    repeat (10) cyc();
    press(10);
    step_btn = 1'b0;
    repeat (10) cyc();
    chk("frz_nopulse", pulses, 0);
    chk("step_run", int'(running), 0);
    frz = 1'b0;
    until_ph(2);
    chk("step_en", int'(cpu_en), 1);
    cyc();
    chk("step_cnt", int'(cycle_count), 7);
    until_ph(2);
    chk("step_once", int'(cpu_en), 0);

    until_ph(3);
    halt_req = 1'b1;
    press(10);
    step_btn = 1'b0;
    until_ph(2);
    chk("bp_step_en", int'(cpu_en), 1);
    cyc();
    chk("bp_step_cnt", int'(cycle_count), 8);
    until_ph(2);
    chk("bp_step_once", int'(cpu_en), 0);
    halt_req = 1'b0;

    until_ph(3);
    press(10);
    step_btn = 1'b0;
    frz = 1'b1;
    repeat (10) cyc();
    rst_n = 1'b0;
    cyc();
    chk("rst_arm_en", int'(cpu_en), 0);
    chk("rst_arm_run", int'(running), 0);
    chk("rst_arm_cnt", int'(cycle_count), 0);
    rst_n = 1'b1;
    cyc();
    chk("rst_arm_after", int'(cpu_en), 0);
    frz = 1'b0;
    pulses = 0;
    repeat (40) cyc();
    chk("rst_arm_nopulse", pulses, 0);
    chk("rst_arm_halt", int'(running), 0);

    run_sw = 1'b1;
    n = 0;
    while (cycle_count != 8'd255 && n < 7000) begin
      cyc();
      n++;
    end
    chk("pre_255", int'(cycle_count), 255);
    until_ph(2);
    chk("wrap_en", int'(cpu_en), 1);
    cyc();
    chk("wrap_cnt", int'(cycle_count), 0);

    until_ph(0);
    rst_n = 1'b0;
    cyc();
    chk("rst_run_en", int'(cpu_en), 0);
    chk("rst_run_run", int'(running), 0);
    chk("rst_run_cnt", int'(cycle_count), 0);
    rst_n = 1'b1;
    pulses = 0;
    lat_run(n);
    chk("rerun_lat", n, 7);
    chk("rst_run_nopulse", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
